// File: rtl/axil_io_pkg.sv
// Shared definitions for the AXI4-Lite I/O responder: response codes,
// register indices (ADDR[3:2]), FSM state types, the latched write request
// payload and a byte-strobe merge helper.
package axil_io_pkg;

   localparam int unsigned ADDR_W = 4;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = DATA_W / 8;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [1:0] REG_OUT     = 2'd0;
   localparam logic [1:0] REG_IN      = 2'd1;
   localparam logic [1:0] REG_TIMER   = 2'd2;
   localparam logic [1:0] REG_SCRATCH = 2'd3;

   typedef enum logic {W_IDLE, W_RESP} wstate_t;
   typedef enum logic {R_IDLE, R_DATA} rstate_t;

   // Write address and data beats, latched independently
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [STRB_W-1:0] strb;
   } wr_req_t;

   // Replace the strobed bytes of old_val with those of new_val
   function automatic logic [DATA_W-1:0] apply_strb(input logic [DATA_W-1:0] old_val,
                                                    input logic [DATA_W-1:0] new_val,
                                                    input logic [STRB_W-1:0] strb);
      logic [DATA_W-1:0] res;
      res = old_val;
      for (int i = 0; i < int'(STRB_W); i++) begin
         if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/axil_io_slave_io_sync.sv
// io_sync: multi-flop synchronizer for asynchronous GPIO inputs.
//  clk, rst  - clock, asynchronous active-high reset (chain clears to 0)
//  d         - asynchronous input bus (WIDTH bits)
//  q         - synchronized copy, STAGES cycles behind d
module io_sync #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] chain [STAGES];

   // Shift register of STAGES flops per bit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(STAGES); i++) chain[i] <= '0;
      end else begin
         chain[0] <= d;
         for (int i = 1; i < int'(STAGES); i++) chain[i] <= chain[i-1];
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/axil_io_slave.sv
// axil_io_slave: AXI4-Lite responder for the core's 4-bit-address I/O port.
// Registers (ADDR[3:2]): 0 GPIO OUT (RW), 1 GPIO IN (RO), 2 TIMER, 3 SCRATCH (RW).
// Unaligned addresses answer SLVERR with no side effect.
// Optional feature macro AXIL_IO_TIMER_EN: free-running 32-bit TIMER at 0x8;
// without it 0x8 answers SLVERR on both read and write.
// Ports: CLK, RST (async active-high); AW/W/B and AR/R AXI4-Lite channels;
// GPIO_OUT (OUT register low bits), GPIO_IN (asynchronous inputs).
module axil_io_slave
   import axil_io_pkg::*;
#(
   parameter int unsigned GPIO_W      = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [31:0] SCRATCH_RST = 32'h0
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [3:0]        AWADDR,
   input  logic              AWVALID,
   output logic              AWREADY,
   input  logic [31:0]       WDATA,
   input  logic [3:0]        WSTRB,
   input  logic              WVALID,
   output logic              WREADY,
   output logic [1:0]        BRESP,
   output logic              BVALID,
   input  logic              BREADY,
   input  logic [3:0]        ARADDR,
   input  logic              ARVALID,
   output logic              ARREADY,
   output logic [31:0]       RDATA,
   output logic [1:0]        RRESP,
   output logic              RVALID,
   input  logic              RREADY,
   output logic [GPIO_W-1:0] GPIO_OUT,
   input  logic [GPIO_W-1:0] GPIO_IN
);

   // OUT is kept 32 bits wide with the unused upper bits forced to zero
   localparam logic [31:0] OUT_MASK = 32'((64'd1 << GPIO_W) - 64'd1);

   wstate_t w_state_q, w_state_d;
   rstate_t r_state_q, r_state_d;
   wr_req_t req_q, req_d;
   logic aw_got_q, aw_got_d, w_got_q, w_got_d;
   logic awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
   logic bvalid_q, bvalid_d, rvalid_q, rvalid_d;
   logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] out_q, scratch_q;
   logic [GPIO_W-1:0] gpio_sync;
   logic do_write_c, wr_ok_c;
   logic [1:0] wr_resp_c, rd_resp_c;
   logic [31:0] rd_data_c, timer_val_c;

   io_sync #(.WIDTH(GPIO_W), .STAGES(SYNC_STAGES)) u_sync (
      .clk (CLK),
      .rst (RST),
      .d   (GPIO_IN),
      .q   (gpio_sync)
   );

`ifdef AXIL_IO_TIMER_EN
   logic [31:0] timer_q;
   // Free-running counter; a write replaces the increment for that cycle
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) timer_q <= '0;
      else if (do_write_c && wr_ok_c && req_q.addr[3:2] == REG_TIMER)
         timer_q <= apply_strb(timer_q, req_q.data, req_q.strb);
      else timer_q <= timer_q + 32'd1;
   end
   assign timer_val_c = timer_q;
`else
   assign timer_val_c = '0;
`endif

   // Write decode: unaligned or missing TIMER -> SLVERR
   always_comb begin
      wr_ok_c = (req_q.addr[1:0] == 2'b00);
`ifndef AXIL_IO_TIMER_EN
      if (req_q.addr[3:2] == REG_TIMER) wr_ok_c = 1'b0;
`endif
      wr_resp_c = wr_ok_c ? RESP_OKAY : RESP_SLVERR;
   end

   // Read decode
   always_comb begin
      rd_data_c = '0;
      rd_resp_c = RESP_OKAY;
      if (ARADDR[1:0] != 2'b00) begin
         rd_resp_c = RESP_SLVERR;
      end else begin
         case (ARADDR[3:2])
            REG_OUT:     rd_data_c = out_q;
            REG_IN:      rd_data_c = 32'(gpio_sync);
`ifdef AXIL_IO_TIMER_EN
            REG_TIMER:   rd_data_c = timer_val_c;
`else
            REG_TIMER:   rd_resp_c = RESP_SLVERR;
`endif
            REG_SCRATCH: rd_data_c = scratch_q;
            default:     rd_data_c = '0;
         endcase
      end
   end

   // Write FSM: collect AW and W in any order, commit, then hold B until taken
   always_comb begin
      w_state_d  = w_state_q;
      req_d      = req_q;
      aw_got_d   = aw_got_q;
      w_got_d    = w_got_q;
      bvalid_d   = bvalid_q;
      bresp_d    = bresp_q;
      do_write_c = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            if (aw_got_q && w_got_q) begin
               do_write_c = 1'b1;
               bresp_d    = wr_resp_c;
               bvalid_d   = 1'b1;
               aw_got_d   = 1'b0;
               w_got_d    = 1'b0;
               w_state_d  = W_RESP;
            end else begin
               if (AWVALID && awready_q) begin
                  aw_got_d   = 1'b1;
                  req_d.addr = AWADDR;
               end
               if (WVALID && wready_q) begin
                  w_got_d    = 1'b1;
                  req_d.data = WDATA;
                  req_d.strb = WSTRB;
               end
            end
         end
         W_RESP: begin
            if (BREADY) begin
               bvalid_d  = 1'b0;
               w_state_d = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
      awready_d = (w_state_d == W_IDLE) && !aw_got_d && !bvalid_d;
      wready_d  = (w_state_d == W_IDLE) && !w_got_d && !bvalid_d;
   end

   // Read FSM: data registered on the AR handshake, held until taken
   always_comb begin
      r_state_d = r_state_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      case (r_state_q)
         R_IDLE: begin
            if (ARVALID && arready_q) begin
               rdata_d   = rd_data_c;
               rresp_d   = rd_resp_c;
               rvalid_d  = 1'b1;
               r_state_d = R_DATA;
            end
         end
         R_DATA: begin
            if (RREADY) begin
               rvalid_d  = 1'b0;
               r_state_d = R_IDLE;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
      arready_d = !rvalid_d;
   end

   // Channel state and registered handshake outputs
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         w_state_q <= W_IDLE;
         r_state_q <= R_IDLE;
         req_q     <= '0;
         aw_got_q  <= 1'b0;
         w_got_q   <= 1'b0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         arready_q <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         rvalid_q  <= 1'b0;
         rresp_q   <= RESP_OKAY;
         rdata_q   <= '0;
      end else begin
         w_state_q <= w_state_d;
         r_state_q <= r_state_d;
         req_q     <= req_d;
         aw_got_q  <= aw_got_d;
         w_got_q   <= w_got_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         arready_q <= arready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         rvalid_q  <= rvalid_d;
         rresp_q   <= rresp_d;
         rdata_q   <= rdata_d;
      end
   end

   // OUT and SCRATCH register file
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         out_q     <= '0;
         scratch_q <= SCRATCH_RST;
      end else if (do_write_c && wr_ok_c) begin
         case (req_q.addr[3:2])
            REG_OUT:     out_q     <= apply_strb(out_q, req_q.data, req_q.strb) & OUT_MASK;
            REG_SCRATCH: scratch_q <= apply_strb(scratch_q, req_q.data, req_q.strb);
            default:     ;
         endcase
      end
   end

   assign AWREADY  = awready_q;
   assign WREADY   = wready_q;
   assign BVALID   = bvalid_q;
   assign BRESP    = bresp_q;
   assign ARREADY  = arready_q;
   assign RVALID   = rvalid_q;
   assign RRESP    = rresp_q;
   assign RDATA    = rdata_q;
   assign GPIO_OUT = out_q[GPIO_W-1:0];

endmodule

// File: tb/tb_axil_io_slave.sv
// Directed self-checking bench for axil_io_slave (GPIO_W=8, SYNC_STAGES=2).
module tb_axil_io_slave;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  awaddr = '0, araddr = '0;
   logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        awready, wready, bvalid, arready, rvalid;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata;
   logic [7:0]  gpio_out;
   logic [7:0]  gpio_in = '0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   axil_io_slave #(.GPIO_W(8), .SYNC_STAGES(2), .SCRATCH_RST(32'h0)) dut (
      .CLK(clk), .RST(rst),
      .AWADDR(awaddr), .AWVALID(awvalid), .AWREADY(awready),
      .WDATA(wdata), .WSTRB(wstrb), .WVALID(wvalid), .WREADY(wready),
      .BRESP(bresp), .BVALID(bvalid), .BREADY(bready),
      .ARADDR(araddr), .ARVALID(arvalid), .ARREADY(arready),
      .RDATA(rdata), .RRESP(rresp), .RVALID(rvalid), .RREADY(rready),
      .GPIO_OUT(gpio_out), .GPIO_IN(gpio_in)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full write transaction with bounded waits; ok=0 on timeout
   task automatic write_reg(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output bit ok);
      bit aw_done, w_done, aw_hs, w_hs;
      int n;
      aw_done = 0; w_done = 0; n = 0;
      awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
      while (!(aw_done && w_done) && n < 20) begin
         aw_hs = awvalid && awready;
         w_hs  = wvalid && wready;
         tick();
         if (aw_hs) begin aw_done = 1; awvalid = 0; end
         if (w_hs)  begin w_done = 1;  wvalid = 0; end
         n++;
      end
      awvalid = 0; wvalid = 0;
      n = 0;
      while (!bvalid && n < 20) begin tick(); n++; end
      ok = aw_done && w_done && bvalid;
      resp = bresp;
      tick();
   endtask

   // Full read transaction with bounded waits; ok=0 on timeout
   task automatic read_reg(input logic [3:0] a, output logic [31:0] d, output logic [1:0] resp,
                           output bit ok);
      bit hs, done;
      int n;
      done = 0; n = 0;
      araddr = a; arvalid = 1; rready = 0;
      while (!done && n < 20) begin
         hs = arready;
         tick();
         if (hs) done = 1;
         n++;
      end
      arvalid = 0;
      n = 0;
      while (!rvalid && n < 20) begin tick(); n++; end
      ok = done && rvalid;
      d = rdata; resp = rresp;
      rready = 1; tick(); rready = 0;
   endtask

   task automatic test_reset();
      rst = 1;
      repeat (3) tick();
      total++;
      if ({awready, wready, arready, bvalid, rvalid, bresp, rresp} !== 9'b0) begin
         bad++; $display("FAIL reset_ctrl: got %b want 0", {awready, wready, arready, bvalid, rvalid, bresp, rresp});
      end
      total++;
      if ({rdata, gpio_out} !== 40'h0) begin
         bad++; $display("FAIL reset_data: rdata=%h gpio_out=%h want 0", rdata, gpio_out);
      end
      rst = 0;
      #1;
      total++;
      if ({awready, wready, arready} !== 3'b000) begin
         bad++; $display("FAIL ready_before_edge: got %b want 000", {awready, wready, arready});
      end
      tick();
      total++;
      if ({awready, wready, arready} !== 3'b111) begin
         bad++; $display("FAIL ready_after_release: got %b want 111", {awready, wready, arready});
      end
   endtask

   task automatic test_write_same_cycle();
      awaddr = 4'h0; wdata = 32'h000000A5; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
      tick();
      awvalid = 0; wvalid = 0;
      total++;
      if ({awready, wready, bvalid} !== 3'b000) begin
         bad++; $display("FAIL wr_after_hs: got %b want 000", {awready, wready, bvalid});
      end
      tick();
      total++;
      if ({bvalid, bresp, gpio_out} !== {1'b1, 2'b00, 8'hA5}) begin
         bad++; $display("FAIL wr_commit: bvalid=%b bresp=%b gpio=%h want 1 00 a5", bvalid, bresp, gpio_out);
      end
      tick();
      total++;
      if ({bvalid, awready, wready} !== 3'b011) begin
         bad++; $display("FAIL wr_b_done: got %b want 011", {bvalid, awready, wready});
      end
   endtask

   task automatic test_w_before_aw();
      logic [31:0] d; logic [1:0] r; bit ok;
      bready = 0;
      wdata = 32'h0000BE00; wstrb = 4'b0010; wvalid = 1;
      tick();
      wvalid = 0;
      total++;
      if ({awready, wready} !== 2'b10) begin
         bad++; $display("FAIL w_only_ready: got %b want 10", {awready, wready});
      end
      tick(); tick();
      awaddr = 4'hC; awvalid = 1;
      tick();
      awvalid = 0;
      total++;
      if ({awready, wready, bvalid} !== 3'b000) begin
         bad++; $display("FAIL aw_late_hs: got %b want 000", {awready, wready, bvalid});
      end
      tick();
      total++;
      if ({bvalid, bresp} !== 3'b100) begin
         bad++; $display("FAIL aw_late_b: got %b want 100", {bvalid, bresp});
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         total++;
         if ({bvalid, bresp, awready, wready} !== 5'b10000) begin
            bad++; $display("FAIL b_hold[%0d]: got %b want 10000", i, {bvalid, bresp, awready, wready});
         end
      end
      bready = 1;
      tick();
      total++;
      if (bvalid !== 1'b0) begin
         bad++; $display("FAIL b_release: bvalid=%b want 0", bvalid);
      end
      read_reg(4'hC, d, r, ok);
      total++;
      if (!ok || d !== 32'h0000BE00 || r !== 2'b00) begin
         bad++; $display("FAIL scratch_strb: ok=%0d data=%h resp=%b want 0000be00 00", ok, d, r);
      end
   endtask

   task automatic test_strobe();
      logic [31:0] d; logic [1:0] r; bit ok;
      write_reg(4'hC, 32'hAABBCCDD, 4'b1001, r, ok);
      read_reg(4'hC, d, r, ok);
      total++;
      if (!ok || d !== 32'hAA00BEDD) begin
         bad++; $display("FAIL scratch_merge: ok=%0d data=%h want aa00bedd", ok, d);
      end
      write_reg(4'h0, 32'hFFFFFF5A, 4'hF, r, ok);
      read_reg(4'h0, d, r, ok);
      total++;
      if (!ok || d !== 32'h0000005A || gpio_out !== 8'h5A) begin
         bad++; $display("FAIL out_width: ok=%0d data=%h gpio=%h want 0000005a 5a", ok, d, gpio_out);
      end
   endtask

   task automatic test_gpio_in();
      gpio_in = 8'h3C;
      repeat (3) tick();
      araddr = 4'h4; arvalid = 1; rready = 0;
      tick();
      arvalid = 0;
      total++;
      if ({rvalid, arready, rresp, rdata} !== {1'b1, 1'b0, 2'b00, 32'h3C}) begin
         bad++; $display("FAIL in_read: rvalid=%b arready=%b rresp=%b rdata=%h want 1 0 00 3c", rvalid, arready, rresp, rdata);
      end
      gpio_in = 8'hFF;
      for (int i = 0; i < 4; i++) begin
         tick();
         total++;
         if ({rvalid, arready, rdata} !== {1'b1, 1'b0, 32'h3C}) begin
            bad++; $display("FAIL r_hold[%0d]: rvalid=%b arready=%b rdata=%h want 1 0 3c", i, rvalid, arready, rdata);
         end
      end
      rready = 1;
      tick();
      rready = 0;
      total++;
      if ({rvalid, arready} !== 2'b01) begin
         bad++; $display("FAIL r_release: got %b want 01", {rvalid, arready});
      end
   endtask

   task automatic test_sync_latency();
      logic [31:0] d; logic [1:0] r; bit ok;
      gpio_in = 8'h5A;
      tick();
      read_reg(4'h4, d, r, ok);
      total++;
      if (!ok || d !== 32'hFF) begin
         bad++; $display("FAIL sync_early: ok=%0d data=%h want 000000ff", ok, d);
      end
      read_reg(4'h4, d, r, ok);
      total++;
      if (!ok || d !== 32'h5A) begin
         bad++; $display("FAIL sync_settled: ok=%0d data=%h want 0000005a", ok, d);
      end
      gpio_in = 8'h66;
      tick(); tick();
      read_reg(4'h4, d, r, ok);
      total++;
      if (!ok || d !== 32'h66) begin
         bad++; $display("FAIL sync_exact: ok=%0d data=%h want 00000066", ok, d);
      end
   endtask

   task automatic test_errors();
      logic [31:0] d; logic [1:0] r; bit ok;
      read_reg(4'h6, d, r, ok);
      total++;
      if (!ok || r !== 2'b10 || d !== 32'h0) begin
         bad++; $display("FAIL rd_unaligned: ok=%0d resp=%b data=%h want 10 0", ok, r, d);
      end
      write_reg(4'h1, 32'h000000FF, 4'hF, r, ok);
      total++;
      if (!ok || r !== 2'b10 || gpio_out !== 8'h5A) begin
         bad++; $display("FAIL wr_unaligned: ok=%0d resp=%b gpio=%h want 10 5a", ok, r, gpio_out);
      end
      write_reg(4'h4, 32'h00000000, 4'hF, r, ok);
      total++;
      if (!ok || r !== 2'b00) begin
         bad++; $display("FAIL wr_in_resp: ok=%0d resp=%b want 00", ok, r);
      end
      read_reg(4'h4, d, r, ok);
      total++;
      if (!ok || d !== 32'h66) begin
         bad++; $display("FAIL in_unwritten: ok=%0d data=%h want 00000066", ok, d);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d; logic [1:0] r; bit ok;
      logic [4:0] exp_b;
      exp_b = 5'b10010;
      bready = 1;
      awaddr = 4'hC; wdata = 32'h00000001; wstrb = 4'hF; awvalid = 1; wvalid = 1;
      tick();
      awaddr = 4'h0; wdata = 32'h00000077;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) tick();
         if (i == 3) begin awvalid = 0; wvalid = 0; end
         total++;
         if (bvalid !== exp_b[i]) begin
            bad++; $display("FAIL b2b_bvalid[%0d]: got %b want %b", i, bvalid, exp_b[i]);
         end
      end
      tick();
      read_reg(4'hC, d, r, ok);
      total++;
      if (!ok || d !== 32'h1 || gpio_out !== 8'h77) begin
         bad++; $display("FAIL b2b_data: ok=%0d scratch=%h gpio=%h want 00000001 77", ok, d, gpio_out);
      end
   endtask

   task automatic test_rw_same_edge();
      logic [31:0] d; logic [1:0] r; bit ok;
      bready = 1;
      awaddr = 4'hC; wdata = 32'hCAFE0000; wstrb = 4'hF; awvalid = 1; wvalid = 1;
      tick();
      awvalid = 0; wvalid = 0;
      araddr = 4'hC; arvalid = 1;
      tick();
      arvalid = 0;
      total++;
      if ({rvalid, rdata} !== {1'b1, 32'h1}) begin
         bad++; $display("FAIL rw_old: rvalid=%b rdata=%h want 1 00000001", rvalid, rdata);
      end
      rready = 1; tick(); rready = 0;
      read_reg(4'hC, d, r, ok);
      total++;
      if (!ok || d !== 32'hCAFE0000) begin
         bad++; $display("FAIL rw_new: ok=%0d data=%h want cafe0000", ok, d);
      end
   endtask

   task automatic test_timer();
      logic [31:0] d; logic [1:0] r; bit ok;
`ifdef AXIL_IO_TIMER_EN
      write_reg(4'h8, 32'hFFFFFFFE, 4'hF, r, ok);
      total++;
      if (!ok || r !== 2'b00) begin
         bad++; $display("FAIL timer_wr: ok=%0d resp=%b want 00", ok, r);
      end
      tick();
      read_reg(4'h8, d, r, ok);
      total++;
      if (!ok || d !== 32'h0 || r !== 2'b00) begin
         bad++; $display("FAIL timer_wrap: ok=%0d data=%h resp=%b want 0 00", ok, d, r);
      end
`else
      read_reg(4'h8, d, r, ok);
      total++;
      if (!ok || d !== 32'h0 || r !== 2'b10) begin
         bad++; $display("FAIL timer_absent_rd: ok=%0d data=%h resp=%b want 0 10", ok, d, r);
      end
      write_reg(4'h8, 32'hFFFFFFFE, 4'hF, r, ok);
      total++;
      if (!ok || r !== 2'b10) begin
         bad++; $display("FAIL timer_absent_wr: ok=%0d resp=%b want 10", ok, r);
      end
`endif
   endtask

   task automatic test_reset_mid();
      logic [31:0] d; logic [1:0] r; bit ok;
      bready = 0;
      awaddr = 4'hC; awvalid = 1;
      tick();
      awvalid = 0;
      araddr = 4'h0; arvalid = 1;
      tick();
      arvalid = 0;
      total++;
      if (rvalid !== 1'b1) begin
         bad++; $display("FAIL mid_rvalid: got %b want 1", rvalid);
      end
      rst = 1;
      #1;
      total++;
      if ({awready, wready, arready, bvalid, rvalid, gpio_out} !== 13'b0) begin
         bad++; $display("FAIL mid_reset: got %b want 0", {awready, wready, arready, bvalid, rvalid, gpio_out});
      end
      tick();
      rst = 0;
      tick();
      wdata = 32'h0000DEAD; wstrb = 4'hF; wvalid = 1;
      tick();
      wvalid = 0;
      repeat (3) tick();
      total++;
      if (bvalid !== 1'b0) begin
         bad++; $display("FAIL mid_aw_dropped: bvalid=%b want 0", bvalid);
      end
      awaddr = 4'h4; awvalid = 1; bready = 1;
      tick();
      awvalid = 0;
      tick();
      total++;
      if ({bvalid, bresp} !== 3'b100) begin
         bad++; $display("FAIL mid_complete: got %b want 100", {bvalid, bresp});
      end
      tick();
      read_reg(4'hC, d, r, ok);
      total++;
      if (!ok || d !== 32'h0) begin
         bad++; $display("FAIL mid_scratch: ok=%0d data=%h want 00000000", ok, d);
      end
   endtask

   initial begin
      test_reset();
      test_write_same_cycle();
      test_w_before_aw();
      test_strobe();
      test_gpio_in();
      test_sync_latency();
      test_errors();
      test_back_to_back();
      test_rw_same_edge();
      test_timer();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
